// File: rtl/sprite_table_if.sv
// Avalon-style write (and optional readback) port of the sprite attribute table.
// Readback signals exist only when SPRITE_TABLE_READBACK_EN is defined.
interface sprite_table_if;
    logic        write;
    logic [4:0]  address;
    logic [24:0] writedata;
`ifdef SPRITE_TABLE_READBACK_EN
    logic        read;
    logic [24:0] readdata;

    modport master (output write, address, writedata, read, input readdata);
    modport slave  (input write, address, writedata, read, output readdata);
`else
    modport master (output write, address, writedata);
    modport slave  (input write, address, writedata);
`endif
endinterface

// File: rtl/sprite_table.sv
// Shadow/active sprite attribute table with a 2-stage per-pixel hit resolver.
// Optional readback port enabled by defining SPRITE_TABLE_READBACK_EN.
module sprite_table #(
    parameter int unsigned NUM_SPRITES = 20,
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned ROM_AW      = 10,
    localparam int unsigned SLOT_W     = $clog2(NUM_SPRITES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    sprite_table_if.slave       bus,
    input  logic                frame_start_i,
    input  logic [9:0]          hcount_i,
    input  logic [9:0]          vcount_i,
    output logic                pix_valid_o,
    output logic [4:0]          pix_id_o,
    output logic [SLOT_W-1:0]   pix_slot_o,
    output logic [ROM_AW-1:0]   rom_addr_o,
    output logic                commit_done_o
);
    localparam int unsigned XW = $clog2(SPRITE_W);
    localparam int unsigned YW = $clog2(SPRITE_H);

    logic [24:0] shadow_q [NUM_SPRITES];
    logic [24:0] shadow_d [NUM_SPRITES];
    logic [24:0] active_q [NUM_SPRITES];
    logic [24:0] active_d [NUM_SPRITES];
    logic        pending_q, pending_d;
    logic        commit_q, commit;
    logic        wr_ok;

    logic [NUM_SPRITES-1:0] hit_q, hit_d;
    logic [XW-1:0]          dx_q [NUM_SPRITES];
    logic [XW-1:0]          dx_d [NUM_SPRITES];
    logic [YW-1:0]          dy_q [NUM_SPRITES];
    logic [YW-1:0]          dy_d [NUM_SPRITES];
    logic [4:0]             id_q [NUM_SPRITES];
    logic [4:0]             id_d [NUM_SPRITES];

    logic                pix_valid_q, pix_valid_d;
    logic [4:0]          pix_id_q, pix_id_d;
    logic [SLOT_W-1:0]   pix_slot_q, pix_slot_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;

    assign wr_ok  = bus.write && (32'(bus.address) < NUM_SPRITES);
    assign commit = frame_start_i && pending_q;

    // The copy takes shadow_q, so a write on the commit edge waits for the next frame.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (bus.write && bus.address == 5'(i)) shadow_d[i] = bus.writedata;
        end
        active_d  = commit ? shadow_q : active_q;
        pending_d = wr_ok || (pending_q && !commit);
    end

    // Stage 1 evaluates against active_d so a pixel on the commit edge sees the new table.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_d[i] = (active_d[i][24:20] != 5'd0)
                && ({1'b0, hcount_i} >= {1'b0, active_d[i][19:10]})
                && ({1'b0, hcount_i} < {1'b0, active_d[i][19:10]} + 11'(SPRITE_W))
                && ({1'b0, vcount_i} >= {1'b0, active_d[i][9:0]})
                && ({1'b0, vcount_i} < {1'b0, active_d[i][9:0]} + 11'(SPRITE_H));
            dx_d[i] = hcount_i[XW-1:0] - active_d[i][10+XW-1:10];
            dy_d[i] = vcount_i[YW-1:0] - active_d[i][YW-1:0];
            id_d[i] = active_d[i][24:20];
        end
    end

    // Descending scan so the lowest hitting slot is assigned last and wins.
    always_comb begin
        pix_valid_d = 1'b0;
        pix_id_d    = '0;
        pix_slot_d  = '0;
        rom_addr_d  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                pix_valid_d = 1'b1;
                pix_id_d    = id_q[i];
                pix_slot_d  = SLOT_W'(i);
                rom_addr_d  = ROM_AW'({dy_q[i], dx_q[i]});
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                dx_q[i]     <= '0;
                dy_q[i]     <= '0;
                id_q[i]     <= '0;
            end
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            hit_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_id_q    <= '0;
            pix_slot_q  <= '0;
            rom_addr_q  <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            commit_q    <= commit;
            hit_q       <= hit_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            id_q        <= id_d;
            pix_valid_q <= pix_valid_d;
            pix_id_q    <= pix_id_d;
            pix_slot_q  <= pix_slot_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    assign pix_valid_o   = pix_valid_q;
    assign pix_id_o      = pix_id_q;
    assign pix_slot_o    = pix_slot_q;
    assign rom_addr_o    = rom_addr_q;
    assign commit_done_o = commit_q;

`ifdef SPRITE_TABLE_READBACK_EN
    logic [24:0] readdata_q, readdata_d;

    always_comb begin
        readdata_d = readdata_q;
        if (bus.read) begin
            readdata_d = '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (bus.address == 5'(i)) readdata_d = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) readdata_q <= '0;
        else         readdata_q <= readdata_d;
    end

    assign bus.readdata = readdata_q;
`endif
endmodule

// File: tb/tb_sprite_table.sv
// Randomised and directed bench for sprite_table against a plain-arithmetic table model.
module tb_sprite_table;
    localparam int N = 20;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] hcount = '0, vcount = '0;
    logic       pix_valid, commit_done;
    logic [4:0] pix_id, pix_slot;
    logic [9:0] rom_addr;

    sprite_table_if bus();

    sprite_table #(
        .NUM_SPRITES(N), .SPRITE_W(32), .SPRITE_H(32), .ROM_AW(10)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .frame_start_i(frame_start),
        .hcount_i(hcount), .vcount_i(vcount), .pix_valid_o(pix_valid), .pix_id_o(pix_id),
        .pix_slot_o(pix_slot), .rom_addr_o(rom_addr), .commit_done_o(commit_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] id;
        logic [4:0] slot;
        logic [9:0] rom;
    } pix_t;

    typedef struct {
        logic        wr;
        int          addr;
        logic [24:0] data;
        logic        fs;
        int          h;
        int          v;
    } stim_t;

    int total = 0, bad = 0;

    logic [24:0] shadow_m [N];
    logic [24:0] active_m [N];
    logic        pending_m;
    pix_t        pend_exp, exp_now;
    logic        exp_commit;
    logic [24:0] exp_rd;

    function automatic logic [24:0] ent(int id, int x, int y);
        return {5'(id), 10'(x), 10'(y)};
    endfunction

    function automatic stim_t mk(logic wr, int addr, logic [24:0] data, logic fs, int h, int v);
        stim_t s;
        s.wr = wr; s.addr = addr; s.data = data; s.fs = fs; s.h = h; s.v = v;
        return s;
    endfunction

    // Scan slots from 0 upward; the first covering sprite wins.
    function automatic pix_t model_pix(int h, int v);
        pix_t p = '0;
        for (int i = 0; i < N; i++) begin
            int id = int'(active_m[i][24:20]);
            int x  = int'(active_m[i][19:10]);
            int y  = int'(active_m[i][9:0]);
            if (id != 0 && h >= x && h < x + 32 && v >= y && v < y + 32) begin
                p.v = 1'b1; p.id = 5'(id); p.slot = 5'(i);
                p.rom = 10'((v - y) * 32 + (h - x));
                return p;
            end
        end
        return p;
    endfunction

    function automatic pix_t obs_pix();
        return {pix_valid, pix_id, pix_slot, rom_addr};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        pending_m = 1'b0; pend_exp = '0; exp_now = '0; exp_commit = 1'b0; exp_rd = '0;
    endtask

    // Drive one cycle of inputs, advance the model over that edge, then sample at +1.
    task automatic step(input stim_t s);
        logic  commit;
        pix_t  e, nxt;
        logic [24:0] rd_nxt;
        bus.write = s.wr; bus.address = 5'(s.addr); bus.writedata = s.data;
        frame_start = s.fs; hcount = 10'(s.h); vcount = 10'(s.v);
        commit = s.fs && pending_m;
        if (commit) active_m = shadow_m;
        e = model_pix(s.h, s.v);
        rd_nxt = exp_rd;
`ifdef SPRITE_TABLE_READBACK_EN
        if (bus.read) rd_nxt = (s.addr < N) ? shadow_m[s.addr] : 25'd0;
`endif
        if (s.wr && s.addr < N) begin
            shadow_m[s.addr] = s.data;
            pending_m = 1'b1;
        end else if (commit) begin
            pending_m = 1'b0;
        end
        nxt = pend_exp;
        pend_exp = e;
        @(posedge clk);
        #1;
        exp_now = nxt; exp_commit = commit; exp_rd = rd_nxt;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        bus.write = 1'b0; frame_start = 1'b0;
`ifdef SPRITE_TABLE_READBACK_EN
        bus.read = 1'b0;
`endif
        #2;
        model_clear();
        total++;
        if ({pix_valid, pix_id, pix_slot, rom_addr, commit_done} !== 22'd0) begin
            bad++;
            $display("FAIL reset_async: got v=%0b id=%0d slot=%0d rom=%0d cd=%0b want all 0",
                     pix_valid, pix_id, pix_slot, rom_addr, commit_done);
        end
`ifdef SPRITE_TABLE_READBACK_EN
        total++;
        if (bus.readdata !== 25'd0) begin
            bad++;
            $display("FAIL reset_readdata: got %h want 0", bus.readdata);
        end
`endif
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        // frame_start with nothing pending, then pixels over the old sprite areas
        for (int k = 0; k < 5; k++) begin
            step(mk(1'b0, 0, '0, (k == 0), 100 + k, 50 + k));
            total++;
            if ({obs_pix(), commit_done} !== {exp_now, exp_commit} || commit_done !== 1'b0
                || pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got v=%0b id=%0d cd=%0b want v=0 cd=0",
                         k, pix_valid, pix_id, commit_done);
            end
        end
    endtask

    task automatic test_basic();
        stim_t t[8];
        pix_t  o[8];
        logic  cd[8];
        t[0] = mk(1'b1, 0, ent(1, 100, 50), 1'b0, 0, 0);
        t[1] = mk(1'b0, 0, '0, 1'b1, 100, 50);
        t[2] = mk(1'b0, 0, '0, 1'b0, 131, 81);
        t[3] = mk(1'b0, 0, '0, 1'b0, 132, 81);
        t[4] = mk(1'b0, 0, '0, 1'b0, 99, 50);
        t[5] = mk(1'b0, 0, '0, 1'b0, 100, 49);
        t[6] = mk(1'b0, 0, '0, 1'b0, 0, 0);
        t[7] = mk(1'b0, 0, '0, 1'b0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(t[k]);
            o[k] = obs_pix(); cd[k] = commit_done;
            total++;
            if ({o[k], cd[k]} !== {exp_now, exp_commit}) begin
                bad++;
                $display("FAIL basic[%0d]: got v=%0b id=%0d slot=%0d rom=%0d cd=%0b want v=%0b id=%0d slot=%0d rom=%0d cd=%0b",
                         k, o[k].v, o[k].id, o[k].slot, o[k].rom, cd[k],
                         exp_now.v, exp_now.id, exp_now.slot, exp_now.rom, exp_commit);
            end
        end
        total += 4;
        if (cd[1] !== 1'b1) begin bad++; $display("FAIL basic_commit: got %0b want 1", cd[1]); end
        if (o[2] !== {1'b1, 5'd1, 5'd0, 10'd0}) begin
            bad++; $display("FAIL basic_origin: got %h want %h", o[2], {1'b1, 5'd1, 5'd0, 10'd0});
        end
        if (o[3] !== {1'b1, 5'd1, 5'd0, 10'd1023}) begin
            bad++; $display("FAIL basic_corner: got %h want %h", o[3], {1'b1, 5'd1, 5'd0, 10'd1023});
        end
        if (o[4].v !== 1'b0) begin bad++; $display("FAIL basic_right_edge: got v=%0b want 0", o[4].v); end
    endtask

    task automatic test_overlap();
        stim_t t[6];
        pix_t  o[6];
        t[0] = mk(1'b1, 2, ent(3, 0, 0), 1'b0, 0, 0);
        t[1] = mk(1'b1, 5, ent(2, 10, 10), 1'b0, 0, 0);
        t[2] = mk(1'b0, 0, '0, 1'b1, 15, 15);
        t[3] = mk(1'b0, 0, '0, 1'b0, 35, 35);
        t[4] = mk(1'b0, 0, '0, 1'b0, 0, 0);
        t[5] = mk(1'b0, 0, '0, 1'b0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(t[k]);
            o[k] = obs_pix();
            total++;
            if ({o[k], commit_done} !== {exp_now, exp_commit}) begin
                bad++;
                $display("FAIL overlap[%0d]: got %h cd=%0b want %h cd=%0b",
                         k, o[k], commit_done, exp_now, exp_commit);
            end
        end
        total += 2;
        if (o[3] !== {1'b1, 5'd3, 5'd2, 10'd495}) begin
            bad++; $display("FAIL overlap_priority: got %h want %h", o[3], {1'b1, 5'd3, 5'd2, 10'd495});
        end
        if (o[4] !== {1'b1, 5'd2, 5'd5, 10'd825}) begin
            bad++; $display("FAIL overlap_lower: got %h want %h", o[4], {1'b1, 5'd2, 5'd5, 10'd825});
        end
    endtask

    task automatic test_pending();
        pix_t o[13];
        logic cd[13];
        for (int k = 0; k < 13; k++) begin
            if (k == 0)      step(mk(1'b1, 1, ent(6, 300, 300), 1'b0, 0, 0));
            else if (k < 9)  step(mk(1'b0, 0, '0, 1'b0, 300 + k, 300 + k));
            else if (k == 9) step(mk(1'b0, 0, '0, 1'b1, 305, 306));
            else             step(mk(1'b0, 0, '0, (k == 10), 305, 306));
            o[k] = obs_pix(); cd[k] = commit_done;
            total++;
            if ({o[k], cd[k]} !== {exp_now, exp_commit}) begin
                bad++;
                $display("FAIL pending[%0d]: got %h cd=%0b want %h cd=%0b", k, o[k], cd[k], exp_now, exp_commit);
            end
        end
        total += 4;
        if (o[9].v !== 1'b0) begin bad++; $display("FAIL pending_hidden: got v=%0b want 0", o[9].v); end
        if (cd[9] !== 1'b1) begin bad++; $display("FAIL pending_commit: got %0b want 1", cd[9]); end
        if (cd[10] !== 1'b0) begin bad++; $display("FAIL pending_once: got %0b want 0", cd[10]); end
        if (o[10] !== {1'b1, 5'd6, 5'd1, 10'd197}) begin
            bad++; $display("FAIL pending_shown: got %h want %h", o[10], {1'b1, 5'd6, 5'd1, 10'd197});
        end
    endtask

    task automatic test_same_cycle();
        stim_t t[9];
        pix_t  o[9];
        logic  cd[9];
        t[0] = mk(1'b1, 3, ent(7, 400, 400), 1'b0, 0, 0);
        t[1] = mk(1'b1, 4, ent(8, 500, 500), 1'b1, 500, 500);
        t[2] = mk(1'b0, 0, '0, 1'b0, 500, 500);
        t[3] = mk(1'b0, 0, '0, 1'b0, 400, 400);
        t[4] = mk(1'b1, 25, ent(9, 600, 600), 1'b0, 600, 600);
        t[5] = mk(1'b0, 0, '0, 1'b1, 500, 500);
        t[6] = mk(1'b0, 0, '0, 1'b0, 600, 600);
        t[7] = mk(1'b0, 0, '0, 1'b0, 0, 0);
        t[8] = mk(1'b0, 0, '0, 1'b1, 600, 600);
        for (int k = 0; k < 9; k++) begin
            step(t[k]);
            o[k] = obs_pix(); cd[k] = commit_done;
            total++;
            if ({o[k], cd[k]} !== {exp_now, exp_commit}) begin
                bad++;
                $display("FAIL same_cycle[%0d]: got %h cd=%0b want %h cd=%0b", k, o[k], cd[k], exp_now, exp_commit);
            end
        end
        total += 7;
        if (cd[1] !== 1'b1) begin bad++; $display("FAIL same_commit1: got %0b want 1", cd[1]); end
        if (o[2].v !== 1'b0 || o[3].v !== 1'b0) begin
            bad++; $display("FAIL same_hidden: got v=%0b,%0b want 0,0", o[2].v, o[3].v);
        end
        if (o[4] !== {1'b1, 5'd7, 5'd3, 10'd0}) begin
            bad++; $display("FAIL same_old_commit: got %h want %h", o[4], {1'b1, 5'd7, 5'd3, 10'd0});
        end
        if (cd[5] !== 1'b1) begin bad++; $display("FAIL same_commit2: got %0b want 1", cd[5]); end
        if (o[6] !== {1'b1, 5'd8, 5'd4, 10'd0}) begin
            bad++; $display("FAIL same_late_write: got %h want %h", o[6], {1'b1, 5'd8, 5'd4, 10'd0});
        end
        if (o[7].v !== 1'b0) begin bad++; $display("FAIL addr25_ignored: got v=%0b want 0", o[7].v); end
        if (cd[8] !== 1'b0) begin bad++; $display("FAIL addr25_no_pending: got %0b want 0", cd[8]); end
    endtask

    task automatic test_edge();
        stim_t t[5];
        pix_t  o[5];
        t[0] = mk(1'b1, 6, ent(5, 1010, 1000), 1'b0, 0, 0);
        t[1] = mk(1'b0, 0, '0, 1'b1, 1023, 1010);
        t[2] = mk(1'b0, 0, '0, 1'b0, 0, 1010);
        t[3] = mk(1'b0, 0, '0, 1'b0, 1009, 1000);
        t[4] = mk(1'b0, 0, '0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(t[k]);
            o[k] = obs_pix();
            total++;
            if ({o[k], commit_done} !== {exp_now, exp_commit}) begin
                bad++;
                $display("FAIL edge[%0d]: got %h cd=%0b want %h cd=%0b", k, o[k], commit_done, exp_now, exp_commit);
            end
        end
        total += 3;
        if (o[2] !== {1'b1, 5'd5, 5'd6, 10'd333}) begin
            bad++; $display("FAIL edge_last_col: got %h want %h", o[2], {1'b1, 5'd5, 5'd6, 10'd333});
        end
        if (o[3].v !== 1'b0) begin bad++; $display("FAIL edge_no_wrap: got v=%0b want 0", o[3].v); end
        if (o[4].v !== 1'b0) begin bad++; $display("FAIL edge_left: got v=%0b want 0", o[4].v); end
    endtask

`ifdef SPRITE_TABLE_READBACK_EN
    task automatic test_readback();
        logic [24:0] got [3];
        step(mk(1'b1, 7, 25'h0ABCDEF, 1'b0, 0, 0));
        bus.read = 1'b1;
        step(mk(1'b0, 7, '0, 1'b0, 0, 0));
        got[0] = bus.readdata;
        step(mk(1'b0, 30, '0, 1'b0, 0, 0));
        got[1] = bus.readdata;
        bus.read = 1'b0;
        step(mk(1'b0, 7, '0, 1'b0, 0, 0));
        got[2] = bus.readdata;
        total += 4;
        if (got[0] !== 25'h0ABCDEF) begin bad++; $display("FAIL readback_slot7: got %h want 0abcdef", got[0]); end
        if (got[1] !== 25'd0) begin bad++; $display("FAIL readback_oob: got %h want 0", got[1]); end
        if (got[2] !== 25'd0) begin bad++; $display("FAIL readback_hold: got %h want 0", got[2]); end
        if (got[2] !== exp_rd) begin bad++; $display("FAIL readback_model: got %h want %h", got[2], exp_rd); end
    endtask
`endif

    function automatic int rcoord();
        if ($urandom_range(0, 5) == 0) return 1023 - int'($urandom_range(0, 45));
        return int'($urandom_range(0, 110));
    endfunction

    task automatic test_random(input int cycles);
        stim_t s;
        int    id;
        for (int k = 0; k < cycles; k++) begin
            id = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31));
            s = mk(($urandom_range(0, 2) == 0), int'($urandom_range(0, 31)),
                   ent(id, rcoord(), rcoord()), ($urandom_range(0, 11) == 0), rcoord(), rcoord());
`ifdef SPRITE_TABLE_READBACK_EN
            bus.read = ($urandom_range(0, 3) == 0);
`endif
            step(s);
            total++;
            if ({obs_pix(), commit_done} !== {exp_now, exp_commit}) begin
                bad++;
                $display("FAIL random[%0d]: got %h cd=%0b want %h cd=%0b", k, obs_pix(), commit_done,
                         exp_now, exp_commit);
            end
`ifdef SPRITE_TABLE_READBACK_EN
            total++;
            if (bus.readdata !== exp_rd) begin
                bad++;
                $display("FAIL random_rd[%0d]: got %h want %h", k, bus.readdata, exp_rd);
            end
`endif
        end
`ifdef SPRITE_TABLE_READBACK_EN
        bus.read = 1'b0;
`endif
    endtask

    initial begin
        bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
`ifdef SPRITE_TABLE_READBACK_EN
        bus.read = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overlap();
        test_pending();
        test_same_cycle();
        test_edge();
`ifdef SPRITE_TABLE_READBACK_EN
        test_readback();
`endif
        test_random(400);
        test_reset();
        test_random(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
